crc32aixm_engine: RTL and testbench

CRC32AIXM_ENGINE -- requirements
Module: crc32aixm_engine

---
 rtl/crc32aixm_pkg.sv | 13 +
 rtl/crc32aixm_step.sv | 15 +
 rtl/crc32aixm_engine.sv | 116 +++++++++++
 tb/tb_crc32aixm_engine.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crc32aixm_pkg.sv
// Shared constants and state type for the CRC-32/AIXM engine.
package crc32aixm_pkg;

  localparam logic [31:0] CRC32AIXM_POLY = 32'h814141AB;
  localparam logic [31:0] CRC32AIXM_INIT = 32'h00000000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/crc32aixm_step.sv
// One MSB-first CRC-32/AIXM bit update; purely combinational.
module crc32aixm_step
  import crc32aixm_pkg::*;
(
  input  logic [31:0] crc,
  input  logic        data_bit,
  output logic [31:0] crc_next
);

  logic fb;

  assign fb       = crc[31] ^ data_bit;
  assign crc_next = {crc[30:0], 1'b0} ^ (fb ? CRC32AIXM_POLY : 32'h0000_0000);

endmodule

// File: rtl/crc32aixm_engine.sv
// CRC-32/AIXM byte-stream engine, bit-serial by default.
// Define CRC32AIXM_BYTE_PAR_EN to fold a whole byte per cycle.
module crc32aixm_engine
  import crc32aixm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] crc_out
);

  state_t      state;
  state_t      state_next;
  logic [31:0] crc;
  logic        accept;

  // Reset is folded in so nothing is offered while it is held.
  assign in_ready = (state == IDLE) && !start && !reset;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == SHIFT);
  assign done     = (state == DONE);
  assign crc_out  = crc;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

`ifdef CRC32AIXM_BYTE_PAR_EN

  logic [31:0] chain [0:8];

  assign chain[0] = crc;

  for (genvar i = 0; i < 8; i++) begin : g_step
    crc32aixm_step u_step (
      .crc      (chain[i]),
      .data_bit (in_data[7-i]),
      .crc_next (chain[i+1])
    );
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && in_last) state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       crc <= 32'h0000_0000;
    else if (start)  crc <= CRC32AIXM_INIT;
    else if (accept) crc <= chain[8];
  end

`else

  logic [7:0]  shreg;
  logic        last_q;
  logic [2:0]  bit_cnt;
  logic [31:0] step_out;

  crc32aixm_step u_step (
    .crc      (crc),
    .data_bit (shreg[7]),
    .crc_next (step_out)
  );

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = SHIFT;
        SHIFT:   if (bit_cnt == 3'd7) state_next = last_q ? DONE : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // The latched byte shifts out MSB first, one bit per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc     <= 32'h0000_0000;
      shreg   <= 8'h00;
      last_q  <= 1'b0;
      bit_cnt <= 3'd0;
    end else if (start) begin
      crc     <= CRC32AIXM_INIT;
      bit_cnt <= 3'd0;
    end else if (accept) begin
      shreg   <= in_data;
      last_q  <= in_last;
      bit_cnt <= 3'd0;
    end else if (state == SHIFT) begin
      crc     <= step_out;
      shreg   <= {shreg[6:0], 1'b0};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

`endif

endmodule

// File: tb/tb_crc32aixm_engine.sv
// Randomised self-checking bench for crc32aixm_engine against a bytewise CRC model.
module tb_crc32aixm_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [31:0] crc_out;

  int checkCount = 0;
  int passCount  = 0;

`ifdef CRC32AIXM_BYTE_PAR_EN
  localparam int LATENCY    = 1;
  localparam int READY_LOW  = 0;
  localparam int BUSY_FIRST = 0;
`else
  localparam int LATENCY    = 9;
  localparam int READY_LOW  = 8;
  localparam int BUSY_FIRST = 1;
`endif

  crc32aixm_engine dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .crc_out  (crc_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: classic bytewise polynomial division, MSB first, no reflection.
  function automatic logic [31:0] crcModel(input logic [31:0] seed, input logic [7:0] msg[$]);
    logic [31:0] c;
    c = seed;
    foreach (msg[i]) begin
      c = c ^ {msg[i], 24'h0};
      for (int k = 0; k < 8; k++)
        c = c[31] ? ((c << 1) ^ 32'h814141AB) : (c << 1);
    end
    return c;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", tag, observed, expected);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte; returns at the first negedge after it was accepted.
  task automatic applyStimulus(input logic [7:0] b, input logic last);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      in_data = 8'($urandom);
      in_last = 1'($urandom);
      @(negedge clk);
      guard++;
    end
    if (!in_ready) checkOutput("ready_timeout", {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
  endtask

  // Measures samples until done, counting in_ready-low samples along the way.
  task automatic waitDone(output int lat, output int readyLow);
    lat      = 1;
    readyLow = 0;
    while (!done && lat < 40) begin
      if (!in_ready) readyLow++;
      in_data = 8'($urandom);
      in_last = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    if (!done) checkOutput("done_timeout", {31'h0, done}, 32'h1);
  endtask

  task automatic sendMessage(input logic [7:0] msg[$]);
    for (int i = 0; i < msg.size(); i++)
      applyStimulus(msg[i], i == msg.size() - 1);
  endtask

  // Counts done pulses seen over a window of cycles.
  task automatic countDone(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  initial begin
    logic [7:0]  msg[$];
    logic [31:0] seed;
    logic [31:0] expCrc;
    string       s;
    int          lat;
    int          readyLow;
    int          pulses;
    int          len;

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_crc",      crc_out,           32'h0);
    checkOutput("rst_busy",     {31'h0, busy},     32'h0);
    checkOutput("rst_done",     {31'h0, done},     32'h0);
    checkOutput("rst_in_ready", {31'h0, in_ready}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

    $display("[TB] check string 123456789");
    pulseStart();
    s = "123456789";
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
    sendMessage(msg);
    waitDone(lat, readyLow);
    checkOutput("check_crc", crc_out, 32'h3010BF7F);
    countDone(12, pulses);
    checkOutput("check_done_single", pulses, 0);
    checkOutput("check_crc_held", crc_out, 32'h3010BF7F);

    $display("[TB] single byte 0x01 timing");
    pulseStart();
    applyStimulus(8'h01, 1'b1);
    checkOutput("b01_busy_first", {31'h0, busy}, BUSY_FIRST);
    waitDone(lat, readyLow);
    checkOutput("b01_latency",   lat,      LATENCY);
    checkOutput("b01_ready_low", readyLow, READY_LOW);
    checkOutput("b01_crc",       crc_out,  32'h814141AB);

    $display("[TB] single byte 0x00");
    pulseStart();
    applyStimulus(8'h00, 1'b1);
    waitDone(lat, readyLow);
    checkOutput("b00_crc", crc_out, 32'h0);
    countDone(12, pulses);
    checkOutput("b00_done_single", pulses, 0);

    $display("[TB] start during shift");
    pulseStart();
    applyStimulus(8'hEE, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("mid_start_crc",  crc_out,       32'h0);
    checkOutput("mid_start_busy", {31'h0, busy}, 32'h0);
    applyStimulus(8'h01, 1'b1);
    waitDone(lat, readyLow);
    checkOutput("mid_start_final", crc_out, 32'h814141AB);

    $display("[TB] reset during shift");
    pulseStart();
    applyStimulus(8'h5A, 1'b1);
    applyStimulus(8'hEE, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_crc",      crc_out,           32'h0);
    checkOutput("mid_rst_busy",     {31'h0, busy},     32'h0);
    checkOutput("mid_rst_done",     {31'h0, done},     32'h0);
    checkOutput("mid_rst_in_ready", {31'h0, in_ready}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_ready_back", {31'h0, in_ready}, 32'h1);
    countDone(12, pulses);
    checkOutput("mid_rst_no_done", pulses, 0);

    $display("[TB] start with in_valid");
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    checkOutput("sv_busy", {31'h0, busy}, 32'h0);
    countDone(12, pulses);
    checkOutput("sv_no_done", pulses, 0);
    checkOutput("sv_crc", crc_out, 32'h0);

    $display("[TB] randomised messages");
    seed = 32'h0;
    for (int m = 0; m < 25; m++) begin
      if ($urandom_range(0, 2) != 0) begin
        pulseStart();
        seed = 32'h0;
      end
      len = $urandom_range(1, 6);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      expCrc = crcModel(seed, msg);
      sendMessage(msg);
      waitDone(lat, readyLow);
      checkOutput($sformatf("rand%0d_latency", m), lat, LATENCY);
      checkOutput($sformatf("rand%0d_crc", m), crc_out, expCrc);
      seed = expCrc;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
